morph_frame_sequencer: RTL

- Frame/line sequencer for the 4-pixel-parallel 3x3 morphology filter (dilate/erode) on the skin-mask video stream.
- Tracks beat position from valid/user(SOF)/last(EOL), latches per-frame config at SOF and generates the filter enable, boundary flags and bypass select.
- After the final line it drives one line of flush beats with upstream stalled, so the filter's line buffers emit the last row.
- Detects malformed lines and resynchronises on the next SOF.

---
 rtl/morph_frame_sequencer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/morph_frame_sequencer.sv
// Frame/line sequencer for the 4-pixel-parallel 3x3 morphology filter.
// Tracks beat position, latches per-frame config at SOF, emits filter enables, flags and flush beats.
module morph_frame_sequencer #(
    parameter int PARALLEL_NUM = 4,
    parameter int H_W          = 12,
    parameter int V_W          = 12,
    parameter int FCNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_user,
    input  logic              i_last,
    output logic              o_ready,
    input  logic              i_cfg_enable,
    input  logic [H_W-1:0]    i_cfg_h_beats,
    input  logic [V_W-1:0]    i_cfg_v_lines,
    input  logic              i_err_clr,
    output logic              o_filt_en,
    output logic              o_flush,
    output logic              o_bypass,
    output logic [H_W-1:0]    o_col,
    output logic [V_W-1:0]    o_row,
    output logic              o_first_col,
    output logic              o_last_col,
    output logic              o_first_row,
    output logic              o_last_row,
    output logic              o_frame_done,
    output logic              o_busy,
    output logic [2:0]        o_err,
    output logic [FCNT_W-1:0] o_frame_cnt
);

    if (PARALLEL_NUM < 1) begin : g_bad_parallel
        $error("PARALLEL_NUM must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Handshake: a beat is consumed on a rising edge where i_valid and o_ready are both 1;
    // o_ready is registered and only drops while flush beats are being generated.
    state_t              state_q, state_d;
    logic [H_W-1:0]      h_q, h_d, col_q, col_d, out_col_q, out_col_d, new_h, cur_c;
    logic [V_W-1:0]      v_q, v_d, row_q, row_d, out_row_q, out_row_d, new_v, cur_r;
    logic                bypass_q, bypass_d, ready_q, ready_d, busy_q, busy_d;
    logic                filt_en_q, filt_en_d, flush_q, flush_d, done_q, done_d;
    logic                first_col_q, first_col_d, last_col_q, last_col_d;
    logic                first_row_q, first_row_d, last_row_q, last_row_d;
    logic [2:0]          err_q, err_d, err_set;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                acc, sof, beat;

    assign new_h = (i_cfg_h_beats < H_W'(2)) ? H_W'(2) : i_cfg_h_beats;
    assign new_v = (i_cfg_v_lines < V_W'(2)) ? V_W'(2) : i_cfg_v_lines;

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        v_d         = v_q;
        col_d       = col_q;
        row_d       = row_q;
        bypass_d    = bypass_q;
        filt_en_d   = 1'b0;
        flush_d     = 1'b0;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        first_col_d = 1'b0;
        last_col_d  = 1'b0;
        first_row_d = 1'b0;
        last_row_d  = 1'b0;
        done_d      = 1'b0;
        fcnt_d      = fcnt_q;
        err_set     = 3'b000;
        acc         = i_valid & ready_q;
        sof         = 1'b0;
        beat        = 1'b0;
        cur_c       = col_q;
        cur_r       = row_q;

        case (state_q)
            ST_IDLE, ST_ERR: begin
                sof = acc & i_user;
            end
            ST_ACTIVE: begin
                if (acc) begin
                    beat = 1'b1;
                    if (i_user && (col_q != '0 || row_q != '0)) begin
                        sof        = 1'b1;
                        err_set[2] = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                filt_en_d = 1'b1;
                flush_d   = 1'b1;
                out_col_d = col_q;
                out_row_d = v_q;
                if (col_q == h_q - H_W'(1)) begin
                    col_d   = '0;
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + FCNT_W'(1);
                    state_d = ST_IDLE;
                end else begin
                    col_d = col_q + H_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A SOF beat restarts position tracking with freshly latched config.
        if (sof) begin
            beat     = 1'b1;
            h_d      = new_h;
            v_d      = new_v;
            bypass_d = ~i_cfg_enable;
            cur_c    = '0;
            cur_r    = '0;
        end

        if (beat) begin
            filt_en_d   = 1'b1;
            out_col_d   = cur_c;
            out_row_d   = cur_r;
            first_col_d = (cur_c == '0);
            last_col_d  = (cur_c == h_d - H_W'(1));
            first_row_d = (cur_r == '0);
            last_row_d  = (cur_r == v_d - V_W'(1));
            state_d     = ST_ACTIVE;
            col_d       = cur_c + H_W'(1);
            row_d       = cur_r;
            if (i_last) begin
                if (cur_c == h_d - H_W'(1)) begin
                    col_d = '0;
                    if (cur_r == v_d - V_W'(1)) begin
                        row_d = '0;
                        if (!bypass_d) begin
                            state_d = ST_FLUSH;
                        end else begin
                            done_d  = 1'b1;
                            fcnt_d  = fcnt_q + FCNT_W'(1);
                            state_d = ST_IDLE;
                        end
                    end else begin
                        row_d = cur_r + V_W'(1);
                    end
                end else begin
                    err_set[0] = 1'b1;
                    state_d    = ST_ERR;
                    col_d      = '0;
                    row_d      = '0;
                end
            end else if (cur_c == h_d - H_W'(1)) begin
                err_set[1] = 1'b1;
                state_d    = ST_ERR;
                col_d      = '0;
                row_d      = '0;
            end
        end

        err_d   = (i_err_clr ? 3'b000 : err_q) | err_set;
        ready_d = (state_d != ST_FLUSH);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            h_q         <= '0;
            v_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            bypass_q    <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            filt_en_q   <= 1'b0;
            flush_q     <= 1'b0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            first_col_q <= 1'b0;
            last_col_q  <= 1'b0;
            first_row_q <= 1'b0;
            last_row_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 3'b000;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            col_q       <= col_d;
            row_q       <= row_d;
            bypass_q    <= bypass_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            filt_en_q   <= filt_en_d;
            flush_q     <= flush_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            first_col_q <= first_col_d;
            last_col_q  <= last_col_d;
            first_row_q <= first_row_d;
            last_row_q  <= last_row_d;
            done_q      <= done_d;
            err_q       <= err_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_filt_en    = filt_en_q;
    assign o_flush      = flush_q;
    assign o_bypass     = bypass_q;
    assign o_col        = out_col_q;
    assign o_row        = out_row_q;
    assign o_first_col  = first_col_q;
    assign o_last_col   = last_col_q;
    assign o_first_row  = first_row_q;
    assign o_last_row   = last_row_q;
    assign o_frame_done = done_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;
    assign o_frame_cnt  = fcnt_q;

endmodule
